// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin arbiter sharing one AES-128 core between two requesters.
// Optional watchdog enabled by `define AES_SCHED_TIMEOUT_EN. Rev 1.0
`default_nettype none

module aes_job_scheduler #(
   parameter int TEXT_WIDTH     = 128,
   parameter int KEY_WIDTH      = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [TEXT_WIDTH-1:0] req0_text_i,
   input  logic [KEY_WIDTH-1:0]  req0_key_i,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [TEXT_WIDTH-1:0] req1_text_i,
   input  logic [KEY_WIDTH-1:0]  req1_key_i,
   output logic                  core_start_o,
   output logic [TEXT_WIDTH-1:0] core_text_o,
   output logic [KEY_WIDTH-1:0]  core_key_o,
   input  logic                  core_done_i,
   input  logic [TEXT_WIDTH-1:0] core_text_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_id_o,
   output logic [TEXT_WIDTH-1:0] rsp_text_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_e                state_q;
   logic                  prio_q;
   logic                  id_q;
   logic                  start_q;
   logic                  rsp_valid_q;
   logic                  busy_q;
   logic [TEXT_WIDTH-1:0] text_q;
   logic [KEY_WIDTH-1:0]  key_q;
   logic [TEXT_WIDTH-1:0] res_q;

`ifdef AES_SCHED_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_q;
   logic              err_q;
`endif

   logic gnt0;
   logic gnt1;
   logic idle;
   logic accept;

   // Port 1 wins only when port 0 is absent or port 1 holds the tie-break pointer.
   assign gnt1   = req1_valid_i & (~req0_valid_i | prio_q);
   assign gnt0   = req0_valid_i & ~gnt1;
   assign idle   = (state_q == IDLE);
   assign accept = idle & (gnt0 | gnt1);

   assign req0_ready_o = idle & gnt0;
   assign req1_ready_o = idle & gnt1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         id_q        <= 1'b0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         text_q      <= '0;
         key_q       <= '0;
         res_q       <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
         wdog_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= ISSUE;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  id_q    <= gnt1;
                  prio_q  <= ~gnt1;
                  text_q  <= gnt1 ? req1_text_i : req0_text_i;
                  key_q   <= gnt1 ? req1_key_i  : req0_key_i;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
`ifdef AES_SCHED_TIMEOUT_EN
               wdog_q  <= '0;
`endif
            end
            WAIT: begin
               // A done pulse takes precedence over a watchdog expiry in the same cycle.
               if (core_done_i) begin
                  state_q     <= RESP;
                  res_q       <= core_text_i;
                  rsp_valid_q <= 1'b1;
`ifdef AES_SCHED_TIMEOUT_EN
                  err_q       <= 1'b0;
               end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q     <= RESP;
                  res_q       <= '0;
                  rsp_valid_q <= 1'b1;
                  err_q       <= 1'b1;
               end else begin
                  wdog_q      <= wdog_q + 1'b1;
`endif
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign core_start_o = start_q;
   assign core_text_o  = text_q;
   assign core_key_o   = key_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = id_q;
   assign rsp_text_o   = res_q;
   assign busy_o       = busy_q;
`ifdef AES_SCHED_TIMEOUT_EN
   assign rsp_err_o    = err_q;
`else
   assign rsp_err_o    = 1'b0;
`endif

endmodule

`default_nettype wire
